// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: PC sequencing controller that arbitrates, buffers and issues redirects, and holds bubbles after boot and after each redirect.
// Optional PC_SEQ_PERF_EN adds the redir_cnt/stall_cnt performance counters.
module pc_seq_ctrl #(
    parameter int BOOT_DELAY   = 2,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_ready,
    input  logic        stall,
    input  logic        br_req,
    input  logic [63:0] br_target,
    input  logic        trap_req,
    input  logic [63:0] trap_vec,
    input  logic        ret_req,
    input  logic [63:0] ret_target,
    output logic        pc_en,
    output logic        pc_branch_taken,
    output logic        pc_trap_taken,
    output logic        pc_ret_taken,
    output logic [63:0] pc_branch,
    output logic [63:0] pc_trap,
    output logic [63:0] pc_ret,
    output logic        flush,
    output logic        redir_pending
`ifdef PC_SEQ_PERF_EN
    ,
    output logic [31:0] redir_cnt,
    output logic [31:0] stall_cnt
`endif
);
    typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;
    localparam logic [3:0] BD  = 4'(BOOT_DELAY);
    localparam logic [3:0] FC1 = 4'(FLUSH_CYCLES - 1);
    state_t      state, state_nx;
    logic [3:0]  boot_cnt, flush_cnt;
    logic        pend_vld, flush_q;
    logic [2:0]  pend_sel, new_sel, cand_sel;
    logic [63:0] pend_tgt, new_tgt, cand_tgt;
    logic        take_new, cand_vld, run, issue;
    // Select vectors are one-hot {trap, branch, ret}, which is also the priority order
    always_comb begin
        new_sel  = trap_req ? 3'b100 : br_req ? 3'b010 : ret_req ? 3'b001 : 3'b000;
        new_tgt  = trap_req ? trap_vec : br_req ? br_target : ret_target;
        take_new = (|new_sel) & (~pend_vld | (new_sel[2] & ~pend_sel[2]));
        cand_vld = pend_vld | (|new_sel);
        cand_sel = take_new ? new_sel : pend_sel;
        cand_tgt = take_new ? new_tgt : pend_tgt;
        run      = (state == RUN) || (state == BOOT && boot_cnt >= BD);
        issue    = ~rst & run & cand_vld & fetch_ready;
        pc_en    = ~rst & (issue | (run & ~cand_vld & fetch_ready & ~stall));
        {pc_trap_taken, pc_branch_taken, pc_ret_taken} = issue ? cand_sel : 3'b000;
        pc_trap   = pc_trap_taken ? cand_tgt : 64'b0;
        pc_branch = pc_branch_taken ? cand_tgt : 64'b0;
        pc_ret    = pc_ret_taken ? cand_tgt : 64'b0;
        flush         = ~rst & flush_q;
        redir_pending = ~rst & pend_vld;
        state_nx = state;
        if (issue)
            state_nx = (FLUSH_CYCLES == 0) ? RUN : FLUSH;
        else if (run || (state == FLUSH && flush_cnt >= FC1))
            state_nx = RUN;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= BOOT;
            boot_cnt  <= 4'd0;
            flush_cnt <= 4'd0;
            flush_q   <= 1'b0;
            pend_vld  <= 1'b0;
            pend_sel  <= 3'b000;
            pend_tgt  <= 64'b0;
        end else begin
            state     <= state_nx;
            boot_cnt  <= (state == BOOT && boot_cnt != 4'hF) ? boot_cnt + 4'd1 : boot_cnt;
            flush_cnt <= (state != FLUSH) ? 4'd0 : (flush_cnt != 4'hF) ? flush_cnt + 4'd1 : flush_cnt;
            flush_q   <= issue;
            pend_vld  <= cand_vld & ~issue;
            pend_sel  <= (cand_vld & ~issue) ? cand_sel : 3'b000;
            pend_tgt  <= (cand_vld & ~issue) ? cand_tgt : 64'b0;
        end
    end
`ifdef PC_SEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            redir_cnt <= 32'd0;
            stall_cnt <= 32'd0;
        end else begin
            redir_cnt <= redir_cnt + 32'(issue);
            stall_cnt <= stall_cnt + 32'(run & ~pc_en & ~issue);
        end
    end
`endif
endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb_pc_seq_ctrl: table-driven check of pc_seq_ctrl with BOOT_DELAY=2, FLUSH_CYCLES=1,
// plus hand-written boot-latency and (with PC_SEQ_PERF_EN) counter sequences.
module tb_pc_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_ready = 1'b0, stall = 1'b0;
    logic        br_req = 1'b0, trap_req = 1'b0, ret_req = 1'b0;
    logic [63:0] br_target = 64'b0, trap_vec = 64'b0, ret_target = 64'b0;
    logic        pc_en, pc_branch_taken, pc_trap_taken, pc_ret_taken, flush, redir_pending;
    logic [63:0] pc_branch, pc_trap, pc_ret;
`ifdef PC_SEQ_PERF_EN
    logic [31:0] redir_cnt, stall_cnt;
`endif
    int n_vec = 0, n_bad = 0;

    always #5 clk = ~clk;

    pc_seq_ctrl #(.BOOT_DELAY(2), .FLUSH_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .fetch_ready(fetch_ready), .stall(stall),
        .br_req(br_req), .br_target(br_target), .trap_req(trap_req), .trap_vec(trap_vec),
        .ret_req(ret_req), .ret_target(ret_target), .pc_en(pc_en),
        .pc_branch_taken(pc_branch_taken), .pc_trap_taken(pc_trap_taken),
        .pc_ret_taken(pc_ret_taken), .pc_branch(pc_branch), .pc_trap(pc_trap),
        .pc_ret(pc_ret), .flush(flush), .redir_pending(redir_pending)
`ifdef PC_SEQ_PERF_EN
        , .redir_cnt(redir_cnt), .stall_cnt(stall_cnt)
`endif
    );

    typedef struct {
        logic        r, fr, st, br, tr, rt;
        logic [63:0] bt, tv, rv;
        logic        en;
        logic [2:0]  tk;
        logic        fl, pd;
        logic [63:0] et;
    } vec_t;

    function automatic vec_t mk(logic r, logic fr, logic st, logic br, logic tr, logic rt,
                                logic [63:0] bt, logic [63:0] tv, logic [63:0] rv,
                                logic en, logic [2:0] tk, logic fl, logic pd, logic [63:0] et);
        vec_t v;
        v.r = r; v.fr = fr; v.st = st; v.br = br; v.tr = tr; v.rt = rt;
        v.bt = bt; v.tv = tv; v.rv = rv;
        v.en = en; v.tk = tk; v.fl = fl; v.pd = pd; v.et = et;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, idx, got, exp);
        end
    endtask

    vec_t tbl[26];

    initial begin
        // rst fr st br tr rt | bt tv rv | en {trap,br,ret} flush pend | target
        tbl[0]  = mk(1,1,0,1,0,0, 64'h900,0,0,        0,3'b000,0,0, 0);
        tbl[1]  = mk(0,1,0,1,0,0, 64'h900,0,0,        0,3'b000,0,0, 0);
        tbl[2]  = mk(0,1,0,0,0,0, 0,0,0,              0,3'b000,0,1, 0);
        tbl[3]  = mk(0,1,0,0,0,0, 0,0,0,              1,3'b010,0,1, 64'h900);
        tbl[4]  = mk(0,1,0,0,0,0, 0,0,0,              0,3'b000,1,0, 0);
        tbl[5]  = mk(0,1,0,1,1,0, 64'h200,64'h100,0,  1,3'b100,0,0, 64'h100);
        tbl[6]  = mk(0,1,0,0,0,0, 0,0,0,              0,3'b000,1,0, 0);
        tbl[7]  = mk(0,1,0,0,0,0, 0,0,0,              1,3'b000,0,0, 0);
        tbl[8]  = mk(0,0,0,1,0,0, 64'h80,0,0,         0,3'b000,0,0, 0);
        tbl[9]  = mk(0,0,0,0,0,0, 0,0,0,              0,3'b000,0,1, 0);
        tbl[10] = mk(0,0,0,0,1,0, 0,64'h40,0,         0,3'b000,0,1, 0);
        tbl[11] = mk(0,1,0,0,0,0, 0,0,0,              1,3'b100,0,1, 64'h40);
        tbl[12] = mk(0,1,0,0,0,0, 0,0,0,              0,3'b000,1,0, 0);
        tbl[13] = mk(0,1,0,0,0,0, 0,0,0,              1,3'b000,0,0, 0);
        tbl[14] = mk(0,1,1,0,0,1, 0,0,64'h1000,       1,3'b001,0,0, 64'h1000);
        tbl[15] = mk(0,1,1,0,0,0, 0,0,0,              0,3'b000,1,0, 0);
        tbl[16] = mk(0,1,1,0,0,0, 0,0,0,              0,3'b000,0,0, 0);
        tbl[17] = mk(0,1,0,0,0,0, 0,0,0,              1,3'b000,0,0, 0);
        tbl[18] = mk(0,1,0,1,0,1, 64'h300,0,64'h400,  1,3'b010,0,0, 64'h300);
        tbl[19] = mk(0,0,0,0,0,1, 0,0,64'h500,        0,3'b000,1,0, 0);
        tbl[20] = mk(0,0,0,0,0,0, 0,0,0,              0,3'b000,0,1, 0);
        tbl[21] = mk(0,1,0,0,0,0, 0,0,0,              1,3'b001,0,1, 64'h500);
        tbl[22] = mk(1,1,0,0,1,0, 0,64'h700,0,        0,3'b000,0,0, 0);
        tbl[23] = mk(0,1,0,0,0,0, 0,0,0,              0,3'b000,0,0, 0);
        tbl[24] = mk(0,1,0,0,0,0, 0,0,0,              0,3'b000,0,0, 0);
        tbl[25] = mk(0,1,0,0,0,0, 0,0,0,              1,3'b000,0,0, 0);

        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            rst = tbl[i].r; fetch_ready = tbl[i].fr; stall = tbl[i].st;
            br_req = tbl[i].br; trap_req = tbl[i].tr; ret_req = tbl[i].rt;
            br_target = tbl[i].bt; trap_vec = tbl[i].tv; ret_target = tbl[i].rv;
            #1;
            chk("pc_en", i, 64'(pc_en), 64'(tbl[i].en));
            chk("taken", i, 64'({pc_trap_taken, pc_branch_taken, pc_ret_taken}), 64'(tbl[i].tk));
            chk("flush", i, 64'(flush), 64'(tbl[i].fl));
            chk("redir_pending", i, 64'(redir_pending), 64'(tbl[i].pd));
            chk("pc_trap", i, pc_trap, tbl[i].tk[2] ? tbl[i].et : 64'b0);
            chk("pc_branch", i, pc_branch, tbl[i].tk[1] ? tbl[i].et : 64'b0);
            chk("pc_ret", i, pc_ret, tbl[i].tk[0] ? tbl[i].et : 64'b0);
        end

        // Boot latency: count idle cycles after reset release until pc_en rises
        begin
            int n;
            @(negedge clk);
            rst = 1'b1; fetch_ready = 1'b1; stall = 1'b0;
            br_req = 1'b0; trap_req = 1'b0; ret_req = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            #1;
            n = 0;
            while (!pc_en && n < 20) begin
                chk("boot_flush", n, 64'(flush), 64'd0);
                @(negedge clk);
                #1;
                n++;
            end
            chk("boot_delay", 0, 64'(n), 64'd2);
        end

`ifdef PC_SEQ_PERF_EN
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            stall = 1'b1;
        end
        @(negedge clk);
        stall = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            br_req = 1'b1; br_target = 64'(k * 16);
            @(negedge clk);
            br_req = 1'b0;
        end
        #1;
        chk("redir_cnt", 0, 64'(redir_cnt), 64'd3);
        chk("stall_cnt", 0, 64'(stall_cnt), 64'd5);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
